addr_burst_gen: RTL and testbench

Address burst generator downstream of the 16-bit address encoder stage. It accepts one base address per valid/ready handshake, then issues a burst of BURST_LEN consecutive addresses to the memory-side consumer, one per accepted output beat. The final beat is flagged with `out_last`. Back-to-back bursts run without a bubble.

---
 rtl/addr_burst_pkg.sv | 24 ++
 rtl/addr_step.sv | 25 ++
 rtl/addr_burst_gen.sv | 97 +++++++++
 tb/tb_addr_burst_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/addr_burst_pkg.sv
// Shared types and helpers for the address burst generator.
// ADDR_BURST_WRAP_EN selects aligned wrap bursts instead of linear ones.
package addr_burst_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    localparam int unsigned AddrWDefault = 16;

    // Exact log2 of a power-of-two burst length in 1..16; returns 0 for a length of 1.
    function automatic int unsigned burst_log2(input int unsigned len);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 5; i++) begin
            if ((32'd1 << i) < len) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/addr_step.sv
// Combinational next-address step: linear increment by default, or aligned
// wrap within the BURST_LEN window when ADDR_BURST_WRAP_EN is defined.
module addr_step
    import addr_burst_pkg::*;
#(
    parameter int unsigned ADDR_W    = AddrWDefault,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic [ADDR_W-1:0] cur,
`ifdef ADDR_BURST_WRAP_EN
    input  logic [ADDR_W-1:0] base,
`endif
    output logic [ADDR_W-1:0] nxt
);

`ifdef ADDR_BURST_WRAP_EN
    // Low bits cycle through the window; upper bits are pinned to the base.
    localparam logic [ADDR_W-1:0] Mask = ADDR_W'(BURST_LEN - 1);

    assign nxt = (base & ~Mask) | ((cur + ADDR_W'(1)) & Mask);
`else
    assign nxt = cur + ADDR_W'(1);
`endif

endmodule

// File: rtl/addr_burst_gen.sv
// Accepts one base address per handshake and emits BURST_LEN consecutive addresses.
// ADDR_BURST_WRAP_EN switches the step from linear to aligned wrap.
module addr_burst_gen
    import addr_burst_pkg::*;
#(
    parameter int unsigned ADDR_W    = AddrWDefault,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned    Log2Len = burst_log2(BURST_LEN);
    localparam int unsigned    CntW    = (Log2Len == 0) ? 1 : Log2Len;
    localparam logic [CntW-1:0] LastCnt = CntW'(BURST_LEN - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] cur_nxt;
    logic              accept;
`ifdef ADDR_BURST_WRAP_EN
    logic [ADDR_W-1:0] base_q, base_d;
`endif

    addr_step #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_step (
        .cur  (cur_q),
`ifdef ADDR_BURST_WRAP_EN
        .base (base_q),
`endif
        .nxt  (cur_nxt)
    );

    assign busy      = (state_q == StBurst);
    assign out_valid = busy;
    assign out_addr  = cur_q;
    assign out_last  = busy && (cnt_q == LastCnt);
    // Combinational from out_ready so a new burst can start without a bubble.
    assign in_ready  = !flush && (!busy || (out_last && out_ready));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
`ifdef ADDR_BURST_WRAP_EN
        base_d  = base_q;
`endif
        if (flush) begin
            state_d = StIdle;
        end else if (accept) begin
            state_d = StBurst;
            cur_d   = in_addr;
            cnt_d   = '0;
`ifdef ADDR_BURST_WRAP_EN
            base_d  = in_addr;
`endif
        end else if (busy && out_ready) begin
            cur_d = cur_nxt;
            cnt_d = cnt_q + CntW'(1);
            if (out_last) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cur_q   <= '0;
            cnt_q   <= '0;
`ifdef ADDR_BURST_WRAP_EN
            base_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
`ifdef ADDR_BURST_WRAP_EN
            base_q  <= base_d;
`endif
        end
    end

endmodule

// File: tb/tb_addr_burst_gen.sv
// Directed self-checking bench for addr_burst_gen (ADDR_W=16, BURST_LEN=4).
// Expected addresses follow ADDR_BURST_WRAP_EN when the bench is built with it.
module tb_addr_burst_gen;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_addr;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    addr_burst_gen #(
        .ADDR_W    (16),
        .BURST_LEN (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_addr   (in_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
        end
    endtask

    // Address of beat i for a burst started at base.
    function automatic logic [15:0] exp_addr(input logic [15:0] base, input int i);
`ifdef ADDR_BURST_WRAP_EN
        return (base & ~16'h0003) | ((base + 16'(i)) & 16'h0003);
`else
        return base + 16'(i);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".out_last"}, 32'(out_last), 32'd0);
    endtask

    // Accept one base address with out_ready high and check all four beats.
    task automatic run_burst(input string tag, input logic [15:0] base);
        in_addr   = base;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("%s.valid%0d", tag, i), 32'(out_valid), 32'd1);
            check($sformatf("%s.addr%0d", tag, i), 32'(out_addr), 32'(exp_addr(base, i)));
            check($sformatf("%s.last%0d", tag, i), 32'(out_last), 32'(i == 3));
            tick();
        end
        #1;
        check_idle({tag, ".after"});
    endtask

    initial begin
        int          beats;
        logic [15:0] b;
        logic        rdy_pat [6];

        rst_n     = 1'b0;
        in_addr   = 16'h0000;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst.out_addr", 32'(out_addr), 32'h0);
        check_idle("rst");
        check("rst.in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_burst("b0010", 16'h0010);
        run_burst("bfffe", 16'hFFFE);

        // Stall: out_ready pattern 1,0,0,1 then high; address must hold while stalled.
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        in_addr   = 16'h0020;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        beats = 0;
        for (int c = 0; c < 6 && beats < 4; c++) begin
            out_ready = rdy_pat[c];
            #1;
            check($sformatf("stall.valid%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("stall.addr%0d", c), 32'(out_addr), 32'(exp_addr(16'h0020, beats)));
            if (out_ready) beats++;
            tick();
        end
        #1;
        check("stall.beats", 32'(beats), 32'd4);
        check_idle("stall.after");

        // Back-to-back bursts with in_valid held: no bubble, in_ready only on final beats.
        in_addr   = 16'h0001;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_addr = 16'h0100;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) in_valid = 1'b0;
            b = (k < 4) ? 16'h0001 : 16'h0100;
            #1;
            check($sformatf("b2b.valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("b2b.addr%0d", k), 32'(out_addr), 32'(exp_addr(b, k % 4)));
            check($sformatf("b2b.in_ready%0d", k), 32'(in_ready), 32'((k % 4) == 3));
            tick();
        end
        #1;
        check_idle("b2b.after");

        // Flush on the second beat with a competing in_valid: no accept, no advance.
        in_addr   = 16'h0030;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_addr  = 16'h0040;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush.addr_beat2", 32'(out_addr), 32'(exp_addr(16'h0030, 1)));
        check("flush.in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle("flush.after");
        check("flush.addr_held", 32'(out_addr), 32'(exp_addr(16'h0030, 1)));

        // Flush in IDLE blocks the accept and leaves the block idle.
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush_idle.in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle("flush_idle.after");

        // Asynchronous reset mid-burst.
        in_addr   = 16'h0050;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        #2;
        check("mid.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.out_addr", 32'(out_addr), 32'h0);
        check_idle("mid.rst");
        check("mid.in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        #1;
        check_idle("mid.release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog keeps the run bounded.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
